// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver with EOL line tracking; pop-to-dout latency is 1 cycle.
// Never stalls the receiver: a write while full with no pop drops the byte and sets sticky overflow.
module uart_rx_fifo #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] EOL   = 8'h0A
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     line_avail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_lines;
  logic [7:0]    r_dout;
  logic          r_valid;
  logic          r_overflow;
  logic          r_rx_ready_q;

  logic          w_wr_evt;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [7:0]    w_rd_byte;
  logic          w_wr_eol;
  logic          w_pop_eol;

  assign empty      = (r_count == '0);
  assign full       = (r_count == CW'(DEPTH));
  assign w_wr_evt   = rx_ready & ~r_rx_ready_q;
  assign w_pop      = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign w_wr       = w_wr_evt & (~full | w_pop);
  assign w_drop     = w_wr_evt & full & ~w_pop;
  assign w_rd_byte  = r_mem[r_rd_ptr];
  assign w_wr_eol   = w_wr & (rx_data == EOL);
  assign w_pop_eol  = w_pop & (w_rd_byte == EOL);

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign line_avail = (r_lines != '0);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_lines      <= '0;
      r_dout       <= 8'h00;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      // Held high so a receiver already asserting ready at release is not seen as a new byte.
      r_rx_ready_q <= 1'b1;
    end else begin
      r_rx_ready_q <= rx_ready;
      r_valid      <= w_pop;

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= w_rd_byte;
      end

      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case ({w_wr_eol, w_pop_eol})
        2'b10:   r_lines <= r_lines + CW'(1);
        2'b01:   r_lines <= r_lines - CW'(1);
        default: r_lines <= r_lines;
      endcase

      // A drop wins over a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: queue-based reference model plus a scoreboard for popped bytes.
module tb_uart_rx_fifo;

  localparam int         DEPTH = 16;
  localparam logic [7:0] EOL   = 8'h0A;

  logic                    clk;
  logic                    rst_n;
  logic [7:0]              rx_data;
  logic                    rx_ready;
  logic                    rd_en;
  logic                    clr_ovf;
  logic [7:0]              dout;
  logic                    valid;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    line_avail;

  uart_rx_fifo #(.DEPTH(DEPTH), .EOL(EOL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .dout       (dout),
    .valid      (valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .line_avail (line_avail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: stored bytes as a plain queue, expected pops in a scoreboard queue.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic       m_prev_rdy;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;

  int  n_checks;
  int  n_fail;
  bit  done;

  function automatic int model_lines();
    int n = 0;
    foreach (m_q[i]) if (m_q[i] == EOL) n++;
    return n;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_prev_rdy = 1'b1;
    m_dout     = 8'h00;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] d, input logic rd, input logic clr);
    logic       wr_evt;
    logic       pop;
    logic       was_full;
    logic       drop;
    logic [7:0] b;
    wr_evt     = r && !m_prev_rdy;
    m_prev_rdy = r;
    was_full   = (m_q.size() == DEPTH);
    pop        = rd && (m_q.size() != 0);
    drop       = 1'b0;
    if (pop) begin
      b = m_q.pop_front();
      exp_q.push_back(b);
      m_dout = b;
    end
    m_valid = pop;
    if (wr_evt) begin
      if (!was_full || pop) m_q.push_back(d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic rd, input logic clr);
    @(negedge clk);
    rx_ready = r;
    rx_data  = d;
    rd_en    = rd;
    clr_ovf  = clr;
    if (rst_n) model_step(r, d, rd, clr);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(rx_ready, rx_data, rd_en, clr_ovf);
  endtask

  // Monitor: compares DUT state and popped bytes against the model each cycle.
  initial begin
    logic [7:0] b;
    while (!done) begin
      @(posedge clk);
      #1;
      chk("valid", valid, m_valid);
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: dout %0h with empty scoreboard at %0t", dout, $time);
        end else begin
          b = exp_q.pop_front();
          chk("pop_data", dout, b);
        end
      end
      chk("sb_pending", exp_q.size(), 0);
      chk("dout_hold", dout, m_dout);
      chk("count", count, m_q.size());
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("line_avail", line_avail, model_lines() != 0);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done     = 1'b0;
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'hA5;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;

    // rx_ready held high through reset release must not write.
    repeat (2) @(negedge clk);
    release_rst();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Basic flow with line tracking, then back-to-back pops.
    wr_byte(8'h41);
    wr_byte(8'h42);
    wr_byte(8'h0A);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reads while empty.
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill past full; the dropped 17th byte is an EOL that must not count.
    for (int i = 0; i < DEPTH; i++) wr_byte(8'h60 + 8'(i));
    wr_byte(8'h0A);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Write while full with a simultaneous pop, then drain.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Write and pop together while empty: only the write happens.
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Wrap-around with occupancy kept small.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom), 1'b0, 1'b0);
      step(1'b0, 8'h00, (m_q.size() >= 3) || ($urandom_range(0, 1) == 1), 1'b0);
    end
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fully random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0) ? EOL : 8'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    // Reset with data stored, then the first byte after release.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    wr_byte(8'h11);
    wr_byte(8'h0A);
    wr_byte(8'h22);
    wr_byte(8'h33);
    wr_byte(8'h44);
    reset_pulse(2);
    release_rst();
    wr_byte(8'h99);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    done = 1'b1;
    @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
